// File: rtl/vend_ctrl_multi_pkg.sv
// Shared definitions for the multi-product vending controller: FSM state
// encoding, coin codes and the coin arithmetic helpers used by the controller.
package vend_ctrl_multi_pkg;

  // Encoding is visible on the state output, so the values are fixed here
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3
  } vend_state_e;

  // Coin codes shared by the acceptor strobe and the change hopper
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_5    = 2'b10;
  localparam logic [1:0] COIN_10   = 2'b11;

  // Wide enough for the largest coin value; callers widen to the credit width
  localparam int COIN_VAL_W = 4;

  // Monetary value of a coin code
  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
    logic [COIN_VAL_W-1:0] val;
    case (code)
      COIN_1:  val = 4'd1;
      COIN_5:  val = 4'd5;
      COIN_10: val = 4'd10;
      default: val = 4'd0;
    endcase
    return val;
  endfunction

  // Largest coin not exceeding the amount still owed; COIN_NONE when nothing is owed
  function automatic logic [1:0] largest_coin(input int unsigned amount);
    logic [1:0] code;
    if (amount >= 32'd10)     code = COIN_10;
    else if (amount >= 32'd5) code = COIN_5;
    else if (amount >= 32'd1) code = COIN_1;
    else                      code = COIN_NONE;
    return code;
  endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Bundle of every front-end, actuator and status signal of the vending
// controller. The master side is the coin acceptor / keypad / actuator world,
// the slave side is the controller itself.
interface vend_ctrl_multi_if #(
  parameter int N_PROD = 4,
  parameter int SEL_W  = 3,
  parameter int AMT_W  = 6
) ();

  // Front end and actuator feedback towards the controller
  logic [1:0]             coin_in;
  logic [SEL_W-1:0]       product_sel;
  logic                   cancel;
  logic                   restock;
  logic [N_PROD*AMT_W-1:0] price_tbl;
  logic                   dispense_ack;
  logic                   change_ack;

  // Controller status and actuator requests
  logic [2:0]             state;
  logic [AMT_W-1:0]       credit;
  logic                   coin_reject;
  logic                   sel_nak;
  logic                   dispense_req;
  logic [SEL_W-1:0]       product_out;
  logic                   change_req;
  logic [1:0]             change_coin;
  logic [N_PROD-1:0]      sold_out;
  logic                   err_timeout;

  modport master (
    output coin_in, product_sel, cancel, restock, price_tbl, dispense_ack, change_ack,
    input  state, credit, coin_reject, sel_nak, dispense_req, product_out,
           change_req, change_coin, sold_out, err_timeout
  );

  modport slave (
    input  coin_in, product_sel, cancel, restock, price_tbl, dispense_ack, change_ack,
    output state, credit, coin_reject, sel_nak, dispense_req, product_out,
           change_req, change_coin, sold_out, err_timeout
  );

endinterface

// File: rtl/vend_ctrl_multi_stock_bank.sv
// Per-product stock counters. All counters reload together on reset or
// restock; a single counter decrements per delivered product and never wraps
// below zero. sold_out is decoded straight from the counter registers.
module vend_ctrl_multi_stock_bank #(
  parameter int N_PROD     = 4,
  parameter int SEL_W      = 3,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              dec_i,
  input  logic [SEL_W-1:0]  dec_code_i,
  output logic [N_PROD-1:0] sold_out_o
);

  logic [STOCK_W-1:0] stock_q [N_PROD];

  // Reload on reset/restock, otherwise decrement the delivered product, saturating at zero
  always_ff @(posedge clk) begin
    if (!reset_n || load_i) begin
      for (int i = 0; i < N_PROD; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
    end else if (dec_i) begin
      for (int i = 0; i < N_PROD; i++) begin
        if (dec_code_i == SEL_W'(i + 1) && stock_q[i] != '0) begin
          stock_q[i] <= stock_q[i] - STOCK_W'(1);
        end
      end
    end
  end

  // A product is sold out exactly when its counter reads zero
  always_comb begin
    sold_out_o = '0;
    for (int i = 0; i < N_PROD; i++) begin
      sold_out_o[i] = (stock_q[i] == '0);
    end
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller. Holds the credit register, runs the
// IDLE/CREDIT/VEND/CHANGE flow, times out abandoned credit and pays change
// back one coin per hopper acknowledge. Every output comes from a register.
module vend_ctrl_multi
  import vend_ctrl_multi_pkg::*;
#(
  parameter int N_PROD      = 4,
  parameter int SEL_W       = 3,
  parameter int AMT_W       = 6,
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  vend_ctrl_multi_if.slave bus
);

  // The idle timer only ever needs to reach TIMEOUT_CYC-1
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  vend_state_e       state_q, state_d;
  logic [AMT_W-1:0]  credit_q, credit_d;
  logic [SEL_W-1:0]  product_out_q, product_out_d;
  logic              dispense_req_q, dispense_req_d;
  logic              change_req_q, change_req_d;
  logic [1:0]        change_coin_q, change_coin_d;
  logic              coin_reject_q, coin_reject_d;
  logic              sel_nak_q, sel_nak_d;
  logic              err_timeout_q, err_timeout_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic [AMT_W-1:0]  coin_amt;
  logic [AMT_W:0]    coin_sum;
  logic              coin_seen;
  logic              coin_fits;
  logic [AMT_W-1:0]  post_coin;
  logic              sel_valid;
  logic              sel_sold;
  logic [AMT_W-1:0]  sel_price;
  logic              activity;
  logic              timeout_hit;
  logic [AMT_W-1:0]  remaining;
  logic              load_stock;
  logic              dec_stock;
  logic [N_PROD-1:0] sold_out;

  vend_ctrl_multi_stock_bank #(
    .N_PROD    (N_PROD),
    .SEL_W     (SEL_W),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT)
  ) u_stock_bank (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (load_stock),
    .dec_i     (dec_stock),
    .dec_code_i(product_out_q),
    .sold_out_o(sold_out)
  );

  // Coin arithmetic is done one bit wider so overflow of the credit register is visible
  always_comb begin
    coin_amt  = AMT_W'(coin_value(bus.coin_in));
    coin_sum  = {1'b0, credit_q} + {1'b0, coin_amt};
    coin_seen = (bus.coin_in != COIN_NONE);
    coin_fits = ~coin_sum[AMT_W];
    post_coin = coin_fits ? coin_sum[AMT_W-1:0] : credit_q;
  end

  // Look up price and availability of the selected product; codes outside 1..N_PROD stay invalid
  always_comb begin
    sel_valid = 1'b0;
    sel_sold  = 1'b0;
    sel_price = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (bus.product_sel == SEL_W'(i + 1)) begin
        sel_valid = 1'b1;
        sel_sold  = sold_out[i];
        sel_price = bus.price_tbl[i*AMT_W +: AMT_W];
      end
    end
  end

  // Any customer action restarts the inactivity window; a zero timeout never fires
  always_comb begin
    activity    = coin_seen || (bus.product_sel != '0) || bus.cancel;
    timeout_hit = (TIMEOUT_CYC != 0) && !activity && (timer_q == TMR_LAST);
  end

  // Next-state logic; change_req/change_coin are primed on entry to CHANGE so payout starts without a bubble
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    product_out_d  = product_out_q;
    dispense_req_d = dispense_req_q;
    change_req_d   = change_req_q;
    change_coin_d  = change_coin_q;
    coin_reject_d  = 1'b0;
    sel_nak_d      = 1'b0;
    err_timeout_d  = 1'b0;
    timer_d        = '0;
    remaining      = credit_q;
    load_stock     = 1'b0;
    dec_stock      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (coin_seen) begin
          if (coin_fits) begin
            credit_d = post_coin;
            state_d  = ST_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        if (bus.product_sel != '0) begin
          sel_nak_d = 1'b1;
        end
        load_stock = bus.restock;
      end

      ST_CREDIT: begin
        credit_d = post_coin;
        if (coin_seen && !coin_fits) begin
          coin_reject_d = 1'b1;
        end
        if (!activity && TIMEOUT_CYC != 0) begin
          timer_d = timer_q + TMR_W'(1);
        end
        if (bus.cancel || timeout_hit) begin
          err_timeout_d = !bus.cancel;
          state_d       = ST_CHANGE;
          change_req_d  = (post_coin != '0);
          change_coin_d = largest_coin(32'(post_coin));
        end else if (bus.product_sel != '0) begin
          if (!sel_valid || sel_sold || post_coin < sel_price) begin
            sel_nak_d = 1'b1;
          end else begin
            credit_d       = post_coin - sel_price;
            product_out_d  = bus.product_sel;
            dispense_req_d = 1'b1;
            state_d        = ST_VEND;
          end
        end
      end

      ST_VEND: begin
        coin_reject_d = coin_seen;
        if (bus.dispense_ack) begin
          dec_stock      = 1'b1;
          dispense_req_d = 1'b0;
          product_out_d  = '0;
          state_d        = ST_CHANGE;
          change_req_d   = (credit_q != '0);
          change_coin_d  = largest_coin(32'(credit_q));
        end
      end

      ST_CHANGE: begin
        coin_reject_d = coin_seen;
        if (credit_q == '0) begin
          state_d       = ST_IDLE;
          change_req_d  = 1'b0;
          change_coin_d = COIN_NONE;
        end else if (change_req_q && bus.change_ack) begin
          remaining     = credit_q - AMT_W'(coin_value(change_coin_q));
          credit_d      = remaining;
          change_req_d  = (remaining != '0);
          change_coin_d = largest_coin(32'(remaining));
        end else begin
          change_req_d  = 1'b1;
          change_coin_d = largest_coin(32'(credit_q));
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single state register for the FSM and all of its registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      product_out_q  <= '0;
      dispense_req_q <= 1'b0;
      change_req_q   <= 1'b0;
      change_coin_q  <= COIN_NONE;
      coin_reject_q  <= 1'b0;
      sel_nak_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      product_out_q  <= product_out_d;
      dispense_req_q <= dispense_req_d;
      change_req_q   <= change_req_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
      sel_nak_q      <= sel_nak_d;
      err_timeout_q  <= err_timeout_d;
      timer_q        <= timer_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.credit       = credit_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.sel_nak      = sel_nak_q;
  assign bus.dispense_req = dispense_req_q;
  assign bus.product_out  = product_out_q;
  assign bus.change_req   = change_req_q;
  assign bus.change_coin  = change_coin_q;
  assign bus.sold_out     = sold_out;
  assign bus.err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi. Dispensed products and change coins are
// predicted when the stimulus is driven and checked when the actuators see them.
module tb_vend_ctrl_multi;

  localparam int N_PROD      = 4;
  localparam int SEL_W       = 3;
  localparam int AMT_W       = 6;
  localparam int STOCK_W     = 4;
  localparam int STOCK_INIT  = 1;
  localparam int TIMEOUT_CYC = 16;
  localparam int MAX_WAIT    = 20;
  localparam int MAX_CREDIT  = 63;

  localparam logic [1:0] CN  = 2'b00;
  localparam logic [1:0] C1  = 2'b01;
  localparam logic [1:0] C5  = 2'b10;
  localparam logic [1:0] C10 = 2'b11;

  logic clk = 1'b0;
  logic reset_n;

  int vectors     = 0;
  int miscompares = 0;
  int modelCredit = 0;
  int prices [N_PROD];
  int stock  [N_PROD];
  int dispQ   [$];
  int changeQ [$];

  always #5 clk = ~clk;

  vend_ctrl_multi_if #(.N_PROD(N_PROD), .SEL_W(SEL_W), .AMT_W(AMT_W)) bus ();

  vend_ctrl_multi #(
    .N_PROD     (N_PROD),
    .SEL_W      (SEL_W),
    .AMT_W      (AMT_W),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Hard stop in case a wait somewhere never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int coinVal(input logic [1:0] code);
    case (code)
      2'b01:   return 1;
      2'b10:   return 5;
      2'b11:   return 10;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] coin, input logic [2:0] sel,
                               input logic cancel, input logic restock);
    bus.coin_in     = coin;
    bus.product_sel = sel;
    bus.cancel      = cancel;
    bus.restock     = restock;
    tick();
    bus.coin_in     = CN;
    bus.product_sel = 3'd0;
    bus.cancel      = 1'b0;
    bus.restock     = 1'b0;
  endtask

  task automatic checkSoldOut(input string tag);
    logic [31:0] exp;
    exp = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (stock[i] == 0) exp[i] = 1'b1;
    end
    checkOutput(tag, 32'(bus.sold_out), exp);
  endtask

  // Greedy 10/5/1 payout expected from the hopper
  task automatic pushChange(input int amount);
    int left;
    left = amount;
    while (left > 0) begin
      if (left >= 10) begin
        changeQ.push_back(3);
        left -= 10;
      end else if (left >= 5) begin
        changeQ.push_back(2);
        left -= 5;
      end else begin
        changeQ.push_back(1);
        left -= 1;
      end
    end
  endtask

  task automatic insertCoin(input logic [1:0] coin);
    logic expReject;
    expReject = (modelCredit + coinVal(coin) > MAX_CREDIT);
    applyStimulus(coin, 3'd0, 1'b0, 1'b0);
    checkOutput("coin_reject", 32'(bus.coin_reject), 32'(expReject));
    if (!expReject) modelCredit += coinVal(coin);
    checkOutput("credit", 32'(bus.credit), modelCredit);
    checkOutput("state_credit", 32'(bus.state), 1);
  endtask

  task automatic selectProd(input logic [2:0] code);
    logic expNak;
    int idx;
    idx = int'(code) - 1;
    if (code == 3'd0 || code > 3'd4) expNak = 1'b1;
    else expNak = (stock[idx] == 0) || (modelCredit < prices[idx]);
    applyStimulus(CN, code, 1'b0, 1'b0);
    checkOutput("sel_nak", 32'(bus.sel_nak), 32'(expNak));
    if (expNak) begin
      checkOutput("state_after_nak", 32'(bus.state), 1);
    end else begin
      modelCredit -= prices[idx];
      dispQ.push_back(int'(code));
      checkOutput("state_vend", 32'(bus.state), 2);
    end
    checkOutput("credit_after_sel", 32'(bus.credit), modelCredit);
  endtask

  task automatic cancelTxn(input logic [1:0] coin);
    applyStimulus(coin, 3'd0, 1'b1, 1'b0);
    modelCredit += coinVal(coin);
    checkOutput("state_cancel", 32'(bus.state), 3);
    checkOutput("credit_cancel", 32'(bus.credit), modelCredit);
    pushChange(modelCredit);
  endtask

  task automatic serviceDispense();
    int n;
    int expCode;
    n = 0;
    while (bus.dispense_req !== 1'b1 && n < MAX_WAIT) begin
      tick();
      n++;
    end
    if (bus.dispense_req !== 1'b1) begin
      checkOutput("dispense_req_wait", 32'(bus.dispense_req), 1);
      return;
    end
    if (dispQ.size() > 0) expCode = dispQ.pop_front();
    else expCode = 0;
    checkOutput("product_out", 32'(bus.product_out), expCode);
    bus.dispense_ack = 1'b1;
    tick();
    bus.dispense_ack = 1'b0;
    if (expCode >= 1 && expCode <= N_PROD && stock[expCode-1] > 0) stock[expCode-1]--;
    checkOutput("dispense_req_drop", 32'(bus.dispense_req), 0);
    checkOutput("product_out_clear", 32'(bus.product_out), 0);
    checkOutput("state_after_vend", 32'(bus.state), 3);
    checkSoldOut("sold_out_after_vend");
    pushChange(modelCredit);
  endtask

  task automatic serviceChange();
    int n;
    int expCoin;
    while (changeQ.size() > 0) begin
      n = 0;
      while (bus.change_req !== 1'b1 && n < MAX_WAIT) begin
        tick();
        n++;
      end
      if (bus.change_req !== 1'b1) begin
        checkOutput("change_req_wait", 32'(bus.change_req), 1);
        changeQ.delete();
        break;
      end
      expCoin = changeQ.pop_front();
      checkOutput("change_coin", 32'(bus.change_coin), expCoin);
      bus.change_ack = 1'b1;
      tick();
      bus.change_ack = 1'b0;
      modelCredit -= coinVal(2'(expCoin));
      checkOutput("credit_after_ack", 32'(bus.credit), modelCredit);
    end
    n = 0;
    while (bus.state !== 3'd0 && n < MAX_WAIT) begin
      checkOutput("no_extra_change", 32'(bus.change_req), 0);
      tick();
      n++;
    end
    checkOutput("state_idle", 32'(bus.state), 0);
    checkOutput("credit_zero", 32'(bus.credit), 0);
    checkOutput("change_req_idle", 32'(bus.change_req), 0);
  endtask

  initial begin
    int n;
    prices = '{15, 20, 25, 30};
    for (int i = 0; i < N_PROD; i++) stock[i] = STOCK_INIT;
    bus.coin_in      = CN;
    bus.product_sel  = 3'd0;
    bus.cancel       = 1'b0;
    bus.restock      = 1'b0;
    bus.dispense_ack = 1'b0;
    bus.change_ack   = 1'b0;
    bus.price_tbl    = {6'd30, 6'd25, 6'd20, 6'd15};
    reset_n          = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_state", 32'(bus.state), 0);
    checkOutput("rst_credit", 32'(bus.credit), 0);
    checkOutput("rst_dispense_req", 32'(bus.dispense_req), 0);
    checkOutput("rst_product_out", 32'(bus.product_out), 0);
    checkOutput("rst_change_req", 32'(bus.change_req), 0);
    checkOutput("rst_coin_reject", 32'(bus.coin_reject), 0);
    checkOutput("rst_sel_nak", 32'(bus.sel_nak), 0);
    checkOutput("rst_err_timeout", 32'(bus.err_timeout), 0);
    checkSoldOut("rst_sold_out");

    $display("[TB] idle select is refused, stray dispense_ack ignored");
    applyStimulus(CN, 3'd1, 1'b0, 1'b0);
    checkOutput("idle_sel_nak", 32'(bus.sel_nak), 1);
    checkOutput("idle_state", 32'(bus.state), 0);
    bus.dispense_ack = 1'b1;
    tick();
    bus.dispense_ack = 1'b0;
    checkOutput("idle_ack_state", 32'(bus.state), 0);
    checkSoldOut("idle_ack_sold_out");

    $display("[TB] exact-price vend, no change");
    insertCoin(C10);
    insertCoin(C5);
    selectProd(3'd1);
    serviceDispense();
    serviceChange();

    $display("[TB] vend with one coin of change");
    insertCoin(C10);
    insertCoin(C10);
    insertCoin(C5);
    selectProd(3'd2);
    serviceDispense();
    serviceChange();

    $display("[TB] cancel refunds 10,1,1");
    insertCoin(C10);
    insertCoin(C1);
    insertCoin(C1);
    cancelTxn(CN);
    serviceChange();

    $display("[TB] insufficient credit and bad code, then cancel with coin");
    insertCoin(C5);
    selectProd(3'd3);
    selectProd(3'd7);
    cancelTxn(C10);
    serviceChange();

    $display("[TB] credit ceiling and coins during VEND");
    for (int i = 0; i < 7; i++) insertCoin(C10);
    for (int i = 0; i < 4; i++) insertCoin(C1);
    selectProd(3'd4);
    applyStimulus(C5, 3'd0, 1'b0, 1'b0);
    checkOutput("vend_coin_reject", 32'(bus.coin_reject), 1);
    checkOutput("vend_credit", 32'(bus.credit), modelCredit);
    applyStimulus(CN, 3'd1, 1'b1, 1'b0);
    checkOutput("vend_ignores_cancel", 32'(bus.state), 2);
    checkOutput("vend_ignores_sel", 32'(bus.sel_nak), 0);
    serviceDispense();
    serviceChange();

    $display("[TB] sold-out product and restock");
    insertCoin(C10);
    insertCoin(C10);
    insertCoin(C10);
    selectProd(3'd4);
    applyStimulus(CN, 3'd0, 1'b0, 1'b1);
    checkSoldOut("restock_ignored_in_credit");
    cancelTxn(CN);
    serviceChange();
    applyStimulus(CN, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < N_PROD; i++) stock[i] = STOCK_INIT;
    checkSoldOut("restock_in_idle");

    $display("[TB] inactivity timeout refunds credit");
    insertCoin(C5);
    n = 0;
    while (bus.err_timeout !== 1'b1 && n < 3 * TIMEOUT_CYC) begin
      tick();
      n++;
    end
    checkOutput("timeout_cycles", n, TIMEOUT_CYC);
    checkOutput("err_timeout", 32'(bus.err_timeout), 1);
    checkOutput("state_timeout", 32'(bus.state), 3);
    pushChange(modelCredit);
    serviceChange();

    $display("[TB] reset during CHANGE");
    insertCoin(C10);
    insertCoin(C10);
    cancelTxn(CN);
    checkOutput("pre_reset_change_req", 32'(bus.change_req), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    changeQ.delete();
    modelCredit = 0;
    checkOutput("reset_mid_state", 32'(bus.state), 0);
    checkOutput("reset_mid_credit", 32'(bus.credit), 0);
    checkOutput("reset_mid_change_req", 32'(bus.change_req), 0);
    checkSoldOut("reset_mid_sold_out");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
